// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the data_memory it drives.
package dmem_pkg;

   localparam int DATA_W     = 32;
   localparam int DEPTH_LOG2 = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie, the port that did not win last is granted.
module rr_arb2 (
   input  logic [1:0] elig,
   input  logic       last_winner,
   output logic       gnt_vld,
   output logic       gnt_id
);

   // Combinational pick; a lone eligible port always wins.
   always_comb begin
      gnt_vld = |elig;
      if (&elig) gnt_id = ~last_winner;
      else       gnt_id = elig[1];
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer in front of the single-ported data_memory.
// One access per two cycles: ISSUE drives the strobes, DONE returns the ack.
module dmem_arbiter #(
   parameter int DATA_W     = dmem_pkg::DATA_W,
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = dmem_pkg::DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              we1,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              err0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              err1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   import dmem_pkg::*;

   state_t                  state;
   logic                    gnt_id;
   logic                    last_winner;
   logic [DEPTH_LOG2-1:0]   g_widx;
   logic [DATA_W-1:0]       g_wdata;
   logic                    g_we;
   logic                    g_err;

   logic [1:0]              elig;
   logic                    arb_vld;
   logic                    arb_id;
   logic [ADDR_W-1:0]       sel_addr;
   logic                    sel_err;
   logic                    in_done;
   logic                    rd_ok;

   // Eligibility: everyone in IDLE, everyone but the port being acked in DONE.
   always_comb begin
      elig = 2'b00;
      case (state)
         IDLE: elig = {req1, req0};
         DONE: begin
            elig         = {req1, req0};
            elig[gnt_id] = 1'b0;
         end
         default: elig = 2'b00;
      endcase
   end

   rr_arb2 u_arb (
      .elig        (elig),
      .last_winner (last_winner),
      .gnt_vld     (arb_vld),
      .gnt_id      (arb_id)
   );

   // Address check on the candidate winner: misaligned or beyond the memory depth.
   always_comb begin
      sel_addr = arb_id ? addr1 : addr0;
      sel_err  = (sel_addr[1:0] != 2'b00) | (|sel_addr[ADDR_W-1:DEPTH_LOG2+2]);
   end

   // Sequencer: latch the winner on entry to ISSUE, ack one cycle later.
   // last_winner only moves on a contested grant, so an uncontested
   // follow-up in DONE does not steal the next tie from the other port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_winner <= 1'b1;
         gnt_id      <= 1'b0;
         g_widx      <= '0;
         g_wdata     <= '0;
         g_we        <= 1'b0;
         g_err       <= 1'b0;
      end else begin
         case (state)
            ISSUE: state <= DONE;
            default: begin
               if (arb_vld) begin
                  state   <= ISSUE;
                  gnt_id  <= arb_id;
                  if (&elig) last_winner <= arb_id;
                  g_widx  <= sel_addr[DEPTH_LOG2+1:2];
                  g_wdata <= arb_id ? wdata1 : wdata0;
                  g_we    <= arb_id ? we1 : we0;
                  g_err   <= sel_err;
               end else begin
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

   // Memory side decodes straight from the latched request; reset kills the strobes.
   assign mem_addr  = {{(ADDR_W-DEPTH_LOG2){1'b0}}, g_widx};
   assign mem_wdata = g_wdata;
   assign mem_write = (state == ISSUE) & g_we  & ~g_err & ~reset;
   assign mem_read  = (state == ISSUE) & ~g_we & ~g_err & ~reset;

   // Requester side: only the granted port sees anything, and only in DONE.
   assign in_done = (state == DONE);
   assign rd_ok   = ~g_we & ~g_err;
   assign ack0    = in_done & ~gnt_id;
   assign ack1    = in_done &  gnt_id;
   assign err0    = ack0 & g_err;
   assign err1    = ack1 & g_err;
   assign rdata0  = (ack0 & rd_ok) ? mem_rdata : '0;
   assign rdata1  = (ack1 & rd_ok) ? mem_rdata : '0;

endmodule
